sprite_plotter: RTL
===================

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns; columns >= SCREEN_W are clipped.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows; rows >= SCREEN_H are clipped.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port begin_draw  input  1  active-low request level (raw key), asynchronous to clk.
REQ-006 SHALL have port x_in  input  8  sprite top-left pixel column.
REQ-007 SHALL have port y_in  input  7  sprite top-left pixel row.
REQ-008 SHALL have port sprite_id_in  input  3  sprite index 0-7.
REQ-009 SHALL have port rom_addr  output  9  sprite ROM address {sprite_id, row[2:0], col[2:0]}.
REQ-010 SHALL have port rom_data  input  3  ROM colour; valid exactly one clk after rom_addr (synchronous ROM).
REQ-011 SHALL have port x_out  output  8  pixel column to frame buffer.
REQ-012 SHALL have port y_out  output  7  pixel row to frame buffer.
REQ-013 SHALL have port colour  output  3  pixel colour.
REQ-014 SHALL have port plot  output  1  write strobe; x_out/y_out/colour valid when high.
REQ-015 SHALL have port busy  output  1  high from request capture until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of sprite.

Function
REQ-017 SHALL pass begin_draw through a two-flop synchronizer and detect a request on a synchronized 1->0 transition.
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAW, FINISH.
REQ-019 IDLE: on detected request (cycle k), SHALL latch x_in, y_in, sprite_id_in, set busy, enter FETCH.
REQ-020 FETCH (cycle k+1): SHALL drive rom_addr = {id,0,0}, enter DRAW; plot low.
REQ-021 DRAW: each cycle SHALL plot the pixel whose address was issued the previous cycle and issue the next address (row-major, col fastest), one pixel per clk.
REQ-022 Pixel p (row r, col c) SHALL be output at cycle k+2+p with x_out = x+c, y_out = y+r, colour = rom_data; last pixel (p=63) at k+65.
REQ-023 Coordinate sums SHALL be computed one bit wider than the output; plot SHALL be low for any pixel with sum column >= SCREEN_W or row >= SCREEN_H (no wrap-around); pixel timing unchanged.
REQ-024 FINISH (cycle k+66): SHALL pulse done for one clk, drop busy same cycle, return to IDLE.
REQ-025 Requests detected while busy SHALL be ignored and not queued; a new request is accepted no earlier than the cycle after done.
REQ-026 Input changes on x_in/y_in/sprite_id_in after capture SHALL not affect the sprite in progress.
REQ-027 rom_addr SHALL hold its last value when not fetching.
REQ-028 Total request-capture-to-done latency SHALL be exactly 66 clk.

Reset
REQ-029 Reset asserted SHALL immediately force IDLE, busy=0, done=0, plot=0, x_out=0, y_out=0, colour=0, rom_addr=0.
REQ-030 Synchronizer and edge-detect flops SHALL reset to 1 (key released), so reset release with begin_draw held low SHALL not generate a request.
REQ-031 Reset mid-sprite SHALL abort without done pulse; no further plot until a new request.

Verification
REQ-032 Request x=10,y=20,id=3, ROM=address[2:0] -> 64 plots at cycles k+2..k+65, first (10,20,colour 0), last (17,27,colour 7), done at k+66.
REQ-033 Request x=156,y=116 -> only 16 plots (cols 156-159, rows 116-119); done still at k+66.
REQ-034 Second begin_draw falling edge at k+30 -> ignored; exactly 64 plots, one done.
REQ-035 Change x_in/id at k+10 -> plotted pixels use captured values throughout.
REQ-036 Assert reset at k+40 -> plot, busy low immediately; no done; next request plots full sprite normally.
REQ-037 Hold begin_draw low through reset release -> no plot, busy stays 0.

Source files
------------

// File: rtl/sprite_plotter.sv
// sprite_plotter
// Draws an 8x8 sprite from a synchronous sprite ROM into a frame buffer,
// one pixel per clock, clipping pixels that fall off the right/bottom edge.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   begin_draw          : raw active-low key, asynchronous to clk
//   x_in, y_in          : sprite top-left column / row
//   sprite_id_in        : sprite index 0-7
//   rom_addr / rom_data : {id,row,col} address, colour returned one clk later
//   x_out, y_out, colour: pixel to write, valid while plot is high
//   plot                : frame-buffer write strobe
//   busy                : high from request capture until done
//   done                : one-cycle pulse when the sprite is finished
module sprite_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       begin_draw,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] sprite_id_in,
  output logic [8:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_FINISH} state_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] id_q, id_d;
  logic [5:0] pix_q, pix_d;
  logic [8:0] rom_addr_q, rom_addr_d;

  logic       req;
  logic       drawing;
  logic [8:0] x_sum;
  logic [7:0] y_sum;

  // Two-flop synchronizer plus an edge-detect flop, all reset to "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= begin_draw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // The reset value of the chain is not a real observation of the key, so a
  // key held low through reset release would look like a press. Requests are
  // only armed once the chain has flushed and the key is seen released.
  always_comb begin
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | (settle_q[1] & sync2_q);
  end

  assign req = armed_q & sync3_q & ~sync2_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    id_d       = id_q;
    pix_d      = pix_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          x_d        = x_in;
          y_d        = y_in;
          id_d       = sprite_id_in;
          rom_addr_d = {sprite_id_in, 6'd0};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        // Pixel 0 is in flight in the ROM; issue pixel 1 ahead of DRAW.
        rom_addr_d = {id_q, 6'd1};
        pix_d      = 6'd0;
        state_d    = S_DRAW;
      end
      S_DRAW: begin
        // The address always runs one pixel ahead of the plotted pixel.
        pix_d = pix_q + 6'd1;
        if (pix_q < 6'd62) rom_addr_d = {id_q, pix_q + 6'd2};
        if (pix_q == 6'd63) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      pix_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      pix_q      <= pix_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Sums are one bit wider so off-screen pixels are clipped, not wrapped.
  assign x_sum   = {1'b0, x_q} + {6'd0, pix_q[2:0]};
  assign y_sum   = {1'b0, y_q} + {5'd0, pix_q[5:3]};
  assign drawing = (state_q == S_DRAW);

  assign plot     = drawing && (x_sum < X_LIM) && (y_sum < Y_LIM);
  assign x_out    = drawing ? x_sum[7:0] : 8'd0;
  assign y_out    = drawing ? y_sum[6:0] : 7'd0;
  assign colour   = drawing ? rom_data : 3'd0;
  assign busy     = (state_q == S_FETCH) || (state_q == S_DRAW);
  assign done     = (state_q == S_FINISH);
  assign rom_addr = rom_addr_q;

endmodule
